// File: rtl/data_mem_arbiter.sv
// Arbiter sharing one single-port data memory between the core load/store path and a debug/loader port.
// Optional ARB_DBG_LOCK_EN adds i_dbg_lock so the loader can hold the memory for atomic bursts.
//
// state     | meaning
// ----------+--------------------------------------------------
// S_IDLE    | no read in flight; at most one grant per cycle
// S_RD_WAIT | read in flight; r_cnt runs RD_LAT..1, no grants
module data_mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_core_req,
    input  logic              i_core_we,
    input  logic [ADDR_W-1:0] i_core_addr,
    input  logic [DATA_W-1:0] i_core_wdata,
    output logic              o_core_gnt,
    output logic              o_core_rvalid,
    output logic [DATA_W-1:0] o_core_rdata,
    output logic              o_core_stall,
    input  logic              i_dbg_req,
    input  logic              i_dbg_we,
    input  logic [ADDR_W-1:0] i_dbg_addr,
    input  logic [DATA_W-1:0] i_dbg_wdata,
    output logic              o_dbg_gnt,
    output logic              o_dbg_rvalid,
    output logic [DATA_W-1:0] o_dbg_rdata,
`ifdef ARB_DBG_LOCK_EN
    input  logic              i_dbg_lock,
`endif
    output logic [ADDR_W-1:0] o_mem_addr_in,
    output logic [DATA_W-1:0] o_mem_in,
    output logic              o_ctrl_mem_read,
    output logic              o_ctrl_mem_write,
    input  logic [DATA_W-1:0] i_mem_out
);

    localparam int   CNT_W    = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);
    localparam logic OWN_CORE = 1'b0;
    localparam logic OWN_DBG  = 1'b1;

    typedef enum logic {S_IDLE, S_RD_WAIT} state_t;

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              r_owner, w_owner_nxt;
    logic              r_last_owner, w_last_owner_nxt;
    logic              w_core_block;
    logic              w_core_ok;
    logic              w_grant;
    logic              w_sel;
    logic              w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wdata;

`ifdef ARB_DBG_LOCK_EN
    logic r_dbg_lock;
    logic r_lock_armed;

    // Lock engages immediately but releases one cycle after i_dbg_lock falls.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_dbg_lock   <= 1'b0;
            r_lock_armed <= 1'b0;
        end else begin
            r_dbg_lock <= i_dbg_lock;
            if (o_dbg_gnt)
                r_lock_armed <= 1'b1;
            else if (o_core_gnt)
                r_lock_armed <= 1'b0;
        end
    end

    assign w_core_block = (i_dbg_lock | r_dbg_lock) & r_lock_armed;
`else
    assign w_core_block = 1'b0;
`endif

    assign w_core_ok = i_core_req & ~w_core_block;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_owner      <= OWN_CORE;
            r_last_owner <= OWN_DBG;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_owner      <= w_owner_nxt;
            r_last_owner <= w_last_owner_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_owner_nxt      = r_owner;
        w_last_owner_nxt = r_last_owner;
        w_grant          = 1'b0;
        w_sel            = OWN_CORE;
        w_we             = 1'b0;
        w_addr           = '0;
        w_wdata          = '0;
        o_core_gnt       = 1'b0;
        o_dbg_gnt        = 1'b0;
        o_core_rvalid    = 1'b0;
        o_dbg_rvalid     = 1'b0;
        o_core_rdata     = '0;
        o_dbg_rdata      = '0;
        o_mem_addr_in    = '0;
        o_mem_in         = '0;
        o_ctrl_mem_read  = 1'b0;
        o_ctrl_mem_write = 1'b0;

        // Outputs are masked while reset is held so every output reads 0.
        if (!i_reset) begin
            case (r_state)
                S_IDLE: begin
                    if (w_core_ok && (!i_dbg_req || r_last_owner == OWN_DBG)) begin
                        w_grant    = 1'b1;
                        w_sel      = OWN_CORE;
                        w_we       = i_core_we;
                        w_addr     = i_core_addr;
                        w_wdata    = i_core_wdata;
                        o_core_gnt = 1'b1;
                    end else if (i_dbg_req) begin
                        w_grant   = 1'b1;
                        w_sel     = OWN_DBG;
                        w_we      = i_dbg_we;
                        w_addr    = i_dbg_addr;
                        w_wdata   = i_dbg_wdata;
                        o_dbg_gnt = 1'b1;
                    end
                    if (w_grant) begin
                        o_mem_addr_in    = w_addr;
                        o_ctrl_mem_write = w_we;
                        o_ctrl_mem_read  = ~w_we;
                        o_mem_in         = w_we ? w_wdata : '0;
                        w_last_owner_nxt = w_sel;
                        if (!w_we) begin
                            w_state_nxt = S_RD_WAIT;
                            w_cnt_nxt   = CNT_W'(RD_LAT);
                            w_owner_nxt = w_sel;
                        end
                    end
                end
                S_RD_WAIT: begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        w_state_nxt = S_IDLE;
                        if (r_owner == OWN_CORE) begin
                            o_core_rvalid = 1'b1;
                            o_core_rdata  = i_mem_out;
                        end else begin
                            o_dbg_rvalid = 1'b1;
                            o_dbg_rdata  = i_mem_out;
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end

        o_core_stall = i_core_req & ~o_core_gnt & ~i_reset;
    end

endmodule
